pipe_latch_sequencer: RTL

- Central hazard and stall sequencer for the 2-wide pipeline.
- Drives the write-enable and bubble-insert (flush) controls of the PC register and the FD, DX, XM and MW pipeline latches, so the latches never decide stalls locally.
- Resolves, by priority, external freeze, branch squash, multi-cycle multdiv hold and load-use stall.
- Tracks multdiv latency with a timeout counter and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_latch_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_latch_sequencer.sv
// Central stall/flush sequencer for the 2-wide pipeline: owns every latch write
// enable and bubble insert, resolving freeze, squash, multdiv hold and load-use.
module pipe_latch_sequencer #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7,
  parameter int PERF_W     = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ext_stall,
  input  logic              branch_taken,
  input  logic              md_start,
  input  logic              md_ready,
  input  logic              load_use,
  output logic              pc_we,
  output logic              fd_we,
  output logic              dx_we,
  output logic              xm_we,
  output logic              mw_we,
  output logic              fd_flush,
  output logic              dx_flush,
  output logic              xm_flush,
  output logic              md_busy,
  output logic              md_error,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_md_cnt, w_md_cnt_nxt;
  logic               r_md_error, w_err_set;
  logic [PERF_W-1:0]  r_stall_cycles;
  logic [4:0]         w_we;     // {pc, fd, dx, xm, mw}
  logic [2:0]         w_flush;  // {fd, dx, xm}

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state        <= RUN;
      r_md_cnt       <= '0;
      r_md_error     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_cnt   <= w_md_cnt_nxt;
      r_md_error <= r_md_error | w_err_set;
      if (!w_we[4] && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  always_comb begin
    w_we         = 5'b00000;
    w_flush      = 3'b000;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_err_set    = 1'b0;
    // Reset and external freeze both leave every latch closed and state untouched.
    if (!ctrl_reset && !ext_stall) begin
      case (r_state)
        RUN: begin
          w_we = 5'b11111;
          if (branch_taken) begin
            w_flush = 3'b110;
          end else if (md_start && !md_ready) begin
            w_we         = 5'b00011;
            w_flush      = 3'b001;
            w_state_nxt  = MD_WAIT;
            w_md_cnt_nxt = '0;
          end else if (md_start) begin
            w_flush = 3'b000;
          end else if (load_use) begin
            w_we    = 5'b00111;
            w_flush = 3'b010;
          end
        end
        MD_WAIT: begin
          if (md_ready || r_md_cnt == MD_LAST) begin
            w_we         = 5'b11111;
            w_state_nxt  = RUN;
            w_md_cnt_nxt = '0;
            w_err_set    = !md_ready;
          end else begin
            w_we         = 5'b00011;
            w_flush      = 3'b001;
            w_md_cnt_nxt = r_md_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign {pc_we, fd_we, dx_we, xm_we, mw_we} = w_we;
  assign {fd_flush, dx_flush, xm_flush}      = w_flush;
  assign md_busy      = (r_state == MD_WAIT);
  assign md_error     = r_md_error;
  assign stall_cycles = r_stall_cycles;

endmodule
